imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Loads a program into the RV32I single-cycle CPU's instruction memory from a byte stream, then releases the CPU by driving its `start` input.
- Sits between an external byte source (UART receiver or bench driver) and the CPU's `start` input plus the imem write port.
- Replaces the hand-timed `start` pulse used in simulation: `start` rises only after the whole image has been committed.

Parameters:
- ADDR_W, 8, imem word-address width.
- MAX_WORDS, 256, largest accepted image in 32-bit words; must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte-source data valid.
- in_ready  out  1  loader can accept a byte.
- in_data  in  8  stream byte.
- imem_we  out  1  imem write strobe, one cycle per word.
- imem_addr  out  ADDR_W  imem word address.
- imem_wdata  out  32  instruction word.
- start  out  1  CPU run enable, drives the CPU's start input.
- busy  out  1  a frame is in progress (states LEN_LO..DRAIN).
- error  out  1  frame rejected; sticky until rst.

Behaviour:
- A byte is accepted on an edge where in_valid && in_ready. in_data is ignored otherwise.
- Frame format, in order:
  - header 8'hA5;
  - LEN_LO, LEN_HI: word count N, little-endian, 16 bits;
  - 4N payload bytes, each word little-endian (first byte is [7:0]);
  - a checksum byte, only when BOOT_CHECKSUM_EN is defined.
- FSM states: IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, DRAIN, RUN, ERR.
- IDLE:
  - accepted 8'hA5 -> LEN_LO;
  - any other accepted byte is dropped and the state stays IDLE.
- LEN_LO: accept -> LEN_HI.
- LEN_HI: accept -> PAYLOAD, or -> ERR if N==0 or N>MAX_WORDS.
- PAYLOAD:
  - a 2-bit byte counter and a word counter track position;
  - the 4th byte of a word sets imem_we=1 on the next cycle, with imem_addr = word index (starting at 0) and imem_wdata = the assembled word;
  - after the 4th byte of word N-1: -> CHECK if BOOT_CHECKSUM_EN, else -> DRAIN.
- CHECK: accept one byte; -> DRAIN if it matches, else -> ERR.
- DRAIN: exactly one cycle, which guarantees the last imem write commits before start rises; -> RUN.
- RUN: terminal state; start=1, in_ready=0. Leaves only on rst.
- ERR: terminal state; error=1, start=0, in_ready=1, and incoming bytes are drained and dropped. Leaves only on rst.
- in_ready is 1 in every state except RUN. The loader never stalls mid-frame.
- Outputs are registered. Reset values:
  - state=IDLE;
  - start=0, busy=0, error=0;
  - imem_we=0, imem_addr=0, imem_wdata=0;
  - in_ready=1.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Reset mid-frame: the frame is abandoned and the state returns to IDLE. The imem contents already written are not cleared.
- The word counter width is ADDR_W+1, so N==MAX_WORDS==2**ADDR_W does not wrap.
- start never asserts in the same cycle as imem_we.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined: the frame carries a trailing byte C, checked in the CHECK state.
  - Acceptance rule: (sum of all 4N payload bytes + C) mod 256 == 0.
  - A running 8-bit sum is kept in the PAYLOAD state.
  - A mismatch goes to ERR, and start never rises.
- Undefined:
  - the CHECK state and the sum register are not built;
  - PAYLOAD goes directly to DRAIN;
  - a checksum byte sent after the payload is ignored, because in_ready is 0 in RUN.

Decomposition:
- Package boot_pkg holds:
  - localparam BOOT_HDR = 8'hA5;
  - the state enum/encoding;
  - LEN_W = 16.
- One sub-module, boot_word_asm: byte-in/word-out shift assembler with a 2-bit lane counter, producing word_valid and word. The FSM, counters and checksum stay in imem_boot_loader.

Test Plan:
- Stream 00, 13, A5, 02, 00, then 13 01 10 00 and 93 01 20 00:
  - imem_we pulses at addr 0 with data 00100113, then at addr 1 with data 00200193;
  - start rises exactly 2 cycles after the last byte is accepted;
  - error stays 0.
- Bytes gapped by random in_valid idles (N=3):
  - same writes as the unthrottled case;
  - busy=1 from LEN_LO until RUN;
  - in_ready=0 once start=1.
- A5, 00, 00:
  - error=1, start stays 0, no imem_we;
  - further bytes are accepted and dropped.
- N=257 with MAX_WORDS=256: goes to ERR after LEN_HI. N=256 with ADDR_W=8: 256 writes, the last at addr FF, then start.
- rst pulsed after 2 payload words of an N=4 frame:
  - state returns to IDLE and start stays 0;
  - a fresh frame loads from addr 0 and then starts.
- With BOOT_CHECKSUM_EN, N=1, word 00000013:
  - C=ED -> start;
  - C=EE -> error=1, start stays 0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame header,
// length-field width and the loader state encoding.
package boot_pkg;

    localparam logic [7:0] BOOT_HDR = 8'hA5;
    localparam int         LEN_W    = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_LO  = 3'd1,
        LEN_HI  = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4,
        DRAIN   = 3'd5,
        RUN     = 3'd6,
        ERR     = 3'd7
    } boot_state_e;

    // A frame is in flight from the first length byte up to the drain cycle.
    function automatic logic is_busy(input boot_state_e s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == PAYLOAD) ||
               (s == CHECK)  || (s == DRAIN);
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word assembler: collects four little-endian bytes and presents the
// completed 32-bit word combinationally alongside the fourth byte.
module boot_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_en,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane;
    logic [23:0] shift;

    // Lane counter and byte shift register; earlier bytes end up in the low lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane  <= 2'd0;
            shift <= 24'd0;
        end else if (in_en) begin
            lane  <= lane + 2'd1;
            shift <= {in_byte, shift[23:8]};
        end else begin
            lane  <= lane;
            shift <= shift;
        end
    end

    // The fourth byte completes the word in the same cycle it is accepted.
    always_comb begin
        word_valid = in_en && (lane == 2'd3);
        word       = {in_byte, shift};
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Frame-driven instruction-memory loader that releases the CPU via start once
// the whole image is committed. Optional trailing checksum: BOOT_CHECKSUM_EN.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              start,
    output logic              busy,
    output logic              error
);

    boot_state_e state;
    boot_state_e next_state;

    logic [7:0]       len_lo;
    logic [ADDR_W:0]  len_words;
    logic [ADDR_W:0]  word_cnt;
    logic [LEN_W-1:0] len_full;
    logic             len_bad;
    logic             last_word;
    logic             accept;
    logic             asm_en;
    logic             word_valid;
    logic [31:0]      word;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum;
`endif

    boot_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .in_en      (asm_en),
        .in_byte    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Handshake, length decode and end-of-payload detection.
    always_comb begin
        accept    = in_valid && in_ready;
        asm_en    = accept && (state == PAYLOAD);
        len_full  = {in_data, len_lo};
        len_bad   = (len_full == {LEN_W{1'b0}}) || (len_full > LEN_W'(MAX_WORDS));
        last_word = ((word_cnt + {{ADDR_W{1'b0}}, 1'b1}) == len_words);
    end

    // Next-state logic; RUN and ERR are only left through rst.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && (in_data == BOOT_HDR)) begin
                    next_state = LEN_LO;
                end else begin
                    next_state = IDLE;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    next_state = LEN_HI;
                end else begin
                    next_state = LEN_LO;
                end
            end
            LEN_HI: begin
                if (accept && len_bad) begin
                    next_state = ERR;
                end else if (accept) begin
                    next_state = PAYLOAD;
                end else begin
                    next_state = LEN_HI;
                end
            end
            PAYLOAD: begin
                if (word_valid && last_word) begin
`ifdef BOOT_CHECKSUM_EN
                    next_state = CHECK;
`else
                    next_state = DRAIN;
`endif
                end else begin
                    next_state = PAYLOAD;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
                if (accept && ((sum + in_data) == 8'h00)) begin
                    next_state = DRAIN;
                end else if (accept) begin
                    next_state = ERR;
                end else begin
                    next_state = CHECK;
                end
            end
`endif
            DRAIN:   next_state = RUN;
            RUN:     next_state = RUN;
            ERR:     next_state = ERR;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Length capture and word counter; the extra counter bit lets N reach 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo    <= 8'd0;
            len_words <= '0;
            word_cnt  <= '0;
        end else begin
            if (accept && (state == LEN_LO)) begin
                len_lo <= in_data;
            end else begin
                len_lo <= len_lo;
            end
            if (accept && (state == LEN_HI)) begin
                len_words <= len_full[ADDR_W:0];
                word_cnt  <= '0;
            end else if (word_valid) begin
                len_words <= len_words;
                word_cnt  <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                len_words <= len_words;
                word_cnt  <= word_cnt;
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running modulo-256 sum of payload bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= 8'd0;
        end else if (accept && (state == LEN_HI)) begin
            sum <= 8'd0;
        end else if (asm_en) begin
            sum <= sum + in_data;
        end else begin
            sum <= sum;
        end
    end
`endif

    // imem write port; address and data hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else if (word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= word;
        end else begin
            imem_we    <= 1'b0;
            imem_addr  <= imem_addr;
            imem_wdata <= imem_wdata;
        end
    end

    // Status outputs track the state; start lags RUN by one cycle so it can never
    // coincide with the final write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            start    <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            start    <= (state == RUN);
            busy     <= is_busy(next_state);
            error    <= (next_state == ERR);
            in_ready <= (next_state != RUN);
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: framing, throttling, length limits,
// mid-frame reset and (with BOOT_CHECKSUM_EN) checksum acceptance.
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        start;
    logic        busy;
    logic        error;

    int checks;
    int errors;
    int overlap;
    logic [7:0]  sum;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    imem_boot_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .start      (start),
        .busy       (busy),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port log and start/write overlap detector.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (imem_we && start) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8]);
            sum = sum + w[8*i +: 8];
        end
    endtask

    task automatic finish_frame();
`ifdef BOOT_CHECKSUM_EN
        send(8'h00 - sum);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        idle(2);
        rst = 1'b0;
        sum = 8'h00;
    endtask

    initial begin
        int base;
        int gap;
        logic [7:0]  bq[$];
        logic [7:0]  b;
        logic [31:0] w;
        checks   = 0;
        errors   = 0;
        overlap  = 0;
        sum      = 8'h00;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset values
        do_reset();
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // Basic two-word frame preceded by junk bytes
        base = wr_addr.size();
        send(8'h00);
        send(8'h13);
        chk("junk_busy", {31'd0, busy}, 32'd0);
        send(8'hA5);
        chk("hdr_busy", {31'd0, busy}, 32'd1);
        send(8'h02);
        send(8'h00);
        sum = 8'h00;
        send_word(32'h00100113);
        send_word(32'h00200193);
        finish_frame();
        chk("t1_start_k0", {31'd0, start}, 32'd0);
        idle(1);
        chk("t1_start_k1", {31'd0, start}, 32'd0);
        idle(1);
        chk("t1_start_k2", {31'd0, start}, 32'd1);
        chk("t1_nwr", wr_addr.size() - base, 32'd2);
        if (wr_addr.size() - base == 2) begin
            chk("t1_addr0", {24'd0, wr_addr[base]}, 32'd0);
            chk("t1_data0", wr_data[base], 32'h00100113);
            chk("t1_addr1", {24'd0, wr_addr[base+1]}, 32'd1);
            chk("t1_data1", wr_data[base+1], 32'h00200193);
        end
        chk("t1_error", {31'd0, error}, 32'd0);
        chk("t1_ready", {31'd0, in_ready}, 32'd0);
        send(8'h77);
        idle(2);
        chk("t1_nwr_after", wr_addr.size() - base, 32'd2);

        // Throttled three-word frame
        do_reset();
        base = wr_addr.size();
        send(8'hA5);
        bq = '{8'h03, 8'h00,
               8'h13, 8'h01, 8'h10, 8'h00,
               8'h93, 8'h01, 8'h20, 8'h00,
               8'h13, 8'h02, 8'h30, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        bq.push_back(8'h00 - 8'h13 - 8'h01 - 8'h10 - 8'h93 - 8'h01 - 8'h20 - 8'h13 - 8'h02 - 8'h30);
`endif
        foreach (bq[i]) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                idle(1);
                chk("t2_busy_gap", {31'd0, busy}, 32'd1);
            end
            send(bq[i]);
        end
        chk("t2_busy_drain", {31'd0, busy}, 32'd1);
        idle(1);
        chk("t2_busy_run", {31'd0, busy}, 32'd0);
        idle(1);
        chk("t2_start", {31'd0, start}, 32'd1);
        chk("t2_ready", {31'd0, in_ready}, 32'd0);
        chk("t2_nwr", wr_addr.size() - base, 32'd3);
        if (wr_addr.size() - base == 3) begin
            chk("t2_data0", wr_data[base], 32'h00100113);
            chk("t2_data1", wr_data[base+1], 32'h00200193);
            chk("t2_addr2", {24'd0, wr_addr[base+2]}, 32'd2);
            chk("t2_data2", wr_data[base+2], 32'h00300213);
        end

        // Zero-length frame goes to ERR and drains later bytes
        do_reset();
        base = wr_addr.size();
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        chk("t3_error", {31'd0, error}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        idle(3);
        chk("t3_error_sticky", {31'd0, error}, 32'd1);
        chk("t3_start", {31'd0, start}, 32'd0);
        chk("t3_ready", {31'd0, in_ready}, 32'd1);
        chk("t3_nwr", wr_addr.size() - base, 32'd0);

        // N=257 exceeds MAX_WORDS
        do_reset();
        send(8'hA5);
        send(8'h01);
        send(8'h01);
        chk("t4_over_error", {31'd0, error}, 32'd1);
        idle(2);
        chk("t4_over_start", {31'd0, start}, 32'd0);

        // N=256 fills the whole address space without wrapping
        do_reset();
        base = wr_addr.size();
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_word({b, ~b, 8'h5A, b});
        end
        finish_frame();
        idle(2);
        chk("t4_full_start", {31'd0, start}, 32'd1);
        chk("t4_full_error", {31'd0, error}, 32'd0);
        chk("t4_full_nwr", wr_addr.size() - base, 32'd256);
        if (wr_addr.size() - base == 256) begin
            chk("t4_full_last_addr", {24'd0, wr_addr[base+255]}, 32'h000000FF);
            for (int i = 0; i < 256; i++) begin
                b = 8'(i);
                w = {b, ~b, 8'h5A, b};
                chk("t4_full_addr", {24'd0, wr_addr[base+i]}, {24'd0, b});
                chk("t4_full_data", wr_data[base+i], w);
            end
        end

        // Reset in the middle of an N=4 frame, then a fresh one-word frame
        do_reset();
        send(8'hA5);
        send(8'h04);
        send(8'h00);
        send_word(32'h11111111);
        send_word(32'h22222222);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t5_start", {31'd0, start}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_error", {31'd0, error}, 32'd0);
        chk("t5_ready", {31'd0, in_ready}, 32'd1);
        base = wr_addr.size();
        sum = 8'h00;
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send_word(32'h00000013);
        finish_frame();
        idle(2);
        chk("t5_restart", {31'd0, start}, 32'd1);
        chk("t5_nwr", wr_addr.size() - base, 32'd1);
        if (wr_addr.size() - base == 1) begin
            chk("t5_addr", {24'd0, wr_addr[base]}, 32'd0);
            chk("t5_data", wr_data[base], 32'h00000013);
        end

`ifdef BOOT_CHECKSUM_EN
        // Checksum accept and reject
        do_reset();
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send_word(32'h00000013);
        send(8'hED);
        idle(2);
        chk("cs_ok_start", {31'd0, start}, 32'd1);
        chk("cs_ok_error", {31'd0, error}, 32'd0);
        do_reset();
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send_word(32'h00000013);
        send(8'hEE);
        idle(2);
        chk("cs_bad_error", {31'd0, error}, 32'd1);
        chk("cs_bad_start", {31'd0, start}, 32'd0);
`endif

        chk("start_we_overlap", overlap, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
